// File: rtl/uart_pkg.sv
// Shared types and timing constants for the 9600-baud UART receive path.
// The bit-period constants are the values the baud divider uses at 50 MHz.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS     = 8;
  localparam int CLKS_PER_BIT       = 5208;
  localparam int CLKS_PER_HALF_BIT  = 2604;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the rs232_rx pin plus an edge-history flop
// that turns a 1->0 transition of the synchronised line into a strobe.
`timescale 1ns/1ps
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Idle line is high, so every flop resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_sync = r_sync[SYNC_STAGES-1];
  assign o_fall    = r_hist & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: frames start/data/stop using mid-bit strobes from the
// baud divider, which it enables through bps_start while a frame is active.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_int,
  output logic                 frame_err,
  output logic [2:0]           dbg_state
);

  localparam int CNT_W = $clog2(DATA_BITS);

  // Handshake with the divider: bps_start high requests timing; a clk_bps
  // pulse is a one-cycle bit-centre strobe and only counts while bps_start is high.

  logic w_rx_sync;
  logic w_fall;
  logic w_strobe;

  rx_state_t              r_state,  w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
  logic                   r_done,   w_done_nxt;
  logic [DATA_BITS-1:0]   r_shift,  w_shift_nxt;
  logic [DATA_BITS-1:0]   r_data,   w_data_nxt;
  logic                   r_busy,   w_busy_nxt;
  logic                   r_valid,  w_valid_nxt;
  logic                   r_ferr,   w_ferr_nxt;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (rs232_rx),
    .o_rx_sync (w_rx_sync),
    .o_fall    (w_fall)
  );

  assign w_strobe = clk_bps & r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_nxt = RX_START;
          w_busy_nxt  = 1'b1;
        end
      end
      RX_START: begin
        if (w_strobe) begin
          if (!w_rx_sync) begin
            w_state_nxt = RX_DATA;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
          end else begin
            // Line already back high at the start-bit centre: glitch.
            w_state_nxt = RX_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      RX_DATA: begin
        if (w_strobe && !r_done) begin
          w_shift_nxt = {w_rx_sync, r_shift[DATA_BITS-1:1]};
          if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = RX_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_strobe) begin
          w_busy_nxt = 1'b0;
          if (w_rx_sync) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low break must return high before a new start is armed.
        if (w_rx_sync) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bps_start = r_busy;
  assign rx_int    = r_busy;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a baud-divider model drives clk_bps end to end, with a
// short bit period so whole frames stay cheap to simulate.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_T    = 64;
  localparam int HALF_T   = BIT_T / 2;
  localparam int CLK_HALF = 10;
  localparam int MAX_CYC  = 90000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_int;
  logic       frame_err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_data;

  int   n_valid = 0, n_ferr = 0, n_bps_rise = 0;
  int   bps_len = 0, last_bps_len = 0, cyc = 0;
  int   last_valid_cyc = 0, prev_valid_cyc = 0;
  logic prev_bps = 1'b0, prev_valid = 1'b0;

  // ---------------- clock / reset ----------------
  always #CLK_HALF clk = ~clk;

  initial begin
    #(MAX_CYC * 2 * CLK_HALF);
    $display("FAIL watchdog: got time limit, required finish before %0d cycles", MAX_CYC);
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  uart_rx #(
    .SYNC_STAGES (2),
    .DATA_BITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_int    (rx_int),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // Baud divider: first strobe half a bit after enable, then every bit.
  int   div_cnt;
  logic div_first_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt        <= 0;
      div_first_done <= 1'b0;
      clk_bps        <= 1'b0;
    end else if (!bps_start) begin
      div_cnt        <= 0;
      div_first_done <= 1'b0;
      clk_bps        <= 1'b0;
    end else begin
      clk_bps <= 1'b0;
      div_cnt <= div_cnt + 1;
      if (div_cnt == (div_first_done ? BIT_T - 1 : HALF_T - 1)) begin
        clk_bps        <= 1'b1;
        div_cnt        <= 0;
        div_first_done <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        model_data = exp_q.pop_front();
        check("rx_data_on_valid", 32'(rx_data), 32'(model_data));
      end
      check("valid_and_ferr_exclusive", 32'(frame_err), 32'd0);
      check("rx_valid_one_cycle", 32'(prev_valid), 32'd0);
    end
    if (frame_err) n_ferr++;
    if (bps_start && !prev_bps) begin
      n_bps_rise++;
      bps_len = 0;
    end
    if (bps_start) bps_len++;
    if (!bps_start && prev_bps) last_bps_len = bps_len;
    prev_bps   = bps_start;
    prev_valid = rx_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bits(input logic b, input int n);
    @(negedge clk);
    rs232_rx = b;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bits(1'b0, BIT_T);
    for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_T);
    drive_bits(stop_b, BIT_T);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bps_start && k < 4 * BIT_T) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_bps_start", 32'(bps_start), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, f0, r0;
    int good_cnt, bad_cnt;
    logic any_high;
    logic [7:0] d;
    logic [7:0] c6;
    logic good;
    int gap;

    vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
    vecs[1] = '{8'hA3, 1'b1, 8'hA3, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[4] = '{8'h5A, 1'b0, 8'hFF, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};
    vecs[6] = '{8'h0F, 1'b1, 8'h0F, 1, 0};

    rst        = 1'b1;
    rs232_rx   = 1'b1;
    model_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bps_start", 32'(bps_start), 32'd0);
    check("rst_rx_int",    32'(rx_int),    32'd0);
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_rx_data",   32'(rx_data),   32'd0);
    check("rst_state",     32'(dbg_state), 32'(RX_IDLE));
    rst = 1'b0;
    drive_bits(1'b1, 2 * BIT_T);

    // Single frame with a one-bit idle gap.
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'h55);
    drive_bits(1'b1, BIT_T);
    send_frame(8'h55, 1'b1);
    drive_bits(1'b1, BIT_T);
    wait_idle();
    check("single_valid_count", 32'(n_valid - v0), 32'd1);
    check("single_ferr_count",  32'(n_ferr - f0),  32'd0);
    check("single_rx_data",     32'(rx_data),      32'h55);
    check("single_bps_len_9p5_bits",
          32'((last_bps_len >= 9 * BIT_T + BIT_T / 4) && (last_bps_len <= 10 * BIT_T)), 32'd1);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      v0 = n_valid; f0 = n_ferr;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_ok);
      drive_bits(1'b1, BIT_T);
      wait_idle();
      check($sformatf("vec%0d_valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ferr", i),  32'(n_ferr - f0),  32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_data", i),  32'(rx_data),      32'(vecs[i].exp_data));
    end

    // Back-to-back frames, no idle gap.
    v0 = n_valid;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    drive_bits(1'b1, BIT_T);
    wait_idle();
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    check("b2b_spacing_10_bits",
          32'((last_valid_cyc - prev_valid_cyc >= 10 * BIT_T - 8) &&
              (last_valid_cyc - prev_valid_cyc <= 10 * BIT_T + 8)), 32'd1);
    check("b2b_rx_data", 32'(rx_data), 32'h0F);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // False start: short low pulse well under half a bit.
    v0 = n_valid; f0 = n_ferr; r0 = n_bps_rise;
    drive_bits(1'b0, 12);
    drive_bits(1'b1, 2 * BIT_T);
    check("false_bps_rose",    32'(n_bps_rise - r0), 32'd1);
    check("false_bps_low",     32'(bps_start),       32'd0);
    check("false_no_valid",    32'(n_valid - v0),    32'd0);
    check("false_no_ferr",     32'(n_ferr - f0),     32'd0);
    check("false_data_kept",   32'(rx_data),         32'(model_data));
    check("false_bps_len_half",
          32'((last_bps_len >= HALF_T - 4) && (last_bps_len <= HALF_T + 4)), 32'd1);

    // Framing error followed by a held-low break.
    v0 = n_valid; f0 = n_ferr; r0 = n_bps_rise;
    send_frame(8'h00, 1'b0);
    drive_bits(1'b0, 3 * BIT_T);
    check("ferr_pulse_count", 32'(n_ferr - f0),     32'd1);
    check("ferr_no_valid",    32'(n_valid - v0),    32'd0);
    check("ferr_data_kept",   32'(rx_data),         32'(model_data));
    check("ferr_no_restart",  32'(n_bps_rise - r0), 32'd1);
    check("ferr_rx_int_low",  32'(rx_int),          32'd0);
    drive_bits(1'b1, 2 * BIT_T);
    check("ferr_high_no_restart", 32'(n_bps_rise - r0), 32'd1);
    check("ferr_back_idle",       32'(dbg_state),       32'(RX_IDLE));

    // Reset in the middle of data bit 4 of 0xC6.
    c6 = 8'hC6;
    drive_bits(1'b0, BIT_T);
    for (int i = 0; i < 4; i++) drive_bits(c6[i], BIT_T);
    drive_bits(c6[4], HALF_T);
    check("midrst_busy_before", 32'(bps_start), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("midrst_bps_start", 32'(bps_start), 32'd0);
    check("midrst_rx_int",    32'(rx_int),    32'd0);
    check("midrst_rx_valid",  32'(rx_valid),  32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_rx_data",   32'(rx_data),   32'd0);
    check("midrst_state",     32'(dbg_state), 32'(RX_IDLE));
    model_data = 8'h00;
    rs232_rx   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bits(1'b1, BIT_T);
    v0 = n_valid;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drive_bits(1'b1, BIT_T);
    wait_idle();
    check("after_rst_valid", 32'(n_valid - v0), 32'd1);
    check("after_rst_data",  32'(rx_data),      32'h3C);

    // Reset held while the line toggles.
    v0 = n_valid; f0 = n_ferr; r0 = n_bps_rise;
    any_high = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rs232_rx = 1'($urandom_range(0, 1));
      if (bps_start || rx_valid || frame_err || rx_int) any_high = 1'b1;
    end
    rs232_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    drive_bits(1'b1, 2 * BIT_T);
    check("rst_idle_outputs_quiet", 32'(any_high),         32'd0);
    check("rst_idle_no_rise",       32'(n_bps_rise - r0),  32'd0);
    check("rst_idle_no_valid",      32'(n_valid - v0),     32'd0);
    check("rst_idle_no_ferr",       32'(n_ferr - f0),      32'd0);

    // Randomised frames against the byte-level reference model.
    v0 = n_valid; f0 = n_ferr;
    good_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      if (good) begin
        exp_q.push_back(d);
        good_cnt++;
        gap = $urandom_range(0, 2);
      end else begin
        bad_cnt++;
        gap = $urandom_range(1, 2);
      end
      send_frame(d, good);
      if (!good) drive_bits(1'b0, $urandom_range(1, BIT_T));
      if (gap > 0) drive_bits(1'b1, gap * BIT_T);
    end
    drive_bits(1'b1, 2 * BIT_T);
    wait_idle();
    check("rand_valid_count", 32'(n_valid - v0), 32'(good_cnt));
    check("rand_ferr_count",  32'(n_ferr - f0),  32'(bad_cnt));
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rand_final_data",  32'(rx_data),      32'(model_data));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
